// File: rtl/clk_div_sched.sv
`default_nettype none
// =============================================================================
// Module      : clk_div_sched
// Description : Single-clock divided-tick scheduler. One free-running counter
//               produces a square wave and a tick enable at clk / 2^(sel+1).
//               Ratio changes are handshaken and applied on a period boundary.
//               Optional macro CLKDIV_TICK_CNT_EN adds a saturating tick_count.
// Revision    : 1.0 - initial release
// =============================================================================
module clk_div_sched #(
    parameter int         CNT_W       = 8,
    parameter logic [2:0] DEFAULT_SEL = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_sel,
    output logic       cfg_ready,
    output logic [2:0] active_sel,
    output logic       busy,
    output logic       div_out,
    output logic       tick,
    output logic [3:0] taps,
    output logic       y
`ifdef CLKDIV_TICK_CNT_EN
    ,
    output logic [7:0] tick_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [2:0]         active_sel_q, active_sel_d;
    logic [2:0]         pend_sel_q,   pend_sel_d;

    logic               w_run;
    logic               w_accept;
    logic               w_tick;
    logic [CNT_W-1:0]   w_mask;

    assign w_run    = (state_q != ST_IDLE);
    assign w_accept = cfg_valid && cfg_ready;

    // Low (active_sel+1) bits all ones marks the final cycle of a period.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (i <= int'(active_sel_q)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_tick = w_run && ((cnt_q & w_mask) == w_mask);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_sel_d = active_sel_q;
        pend_sel_d   = pend_sel_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (w_accept) begin
                    active_sel_d = cfg_sel;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (w_accept) begin
                        active_sel_d = cfg_sel;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (w_accept) begin
                        pend_sel_d = cfg_sel;
                        state_d    = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                // Disable takes priority over the boundary; either way the
                // held request is applied and counting restarts from zero.
                if (!en) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    active_sel_d = pend_sel_q;
                end else if (w_tick) begin
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    active_sel_d = pend_sel_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            active_sel_q <= DEFAULT_SEL;
            pend_sel_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_sel_q <= active_sel_d;
            pend_sel_q   <= pend_sel_d;
        end
    end

    assign cfg_ready  = (state_q != ST_PEND);
    assign busy       = (state_q == ST_PEND);
    assign active_sel = active_sel_q;
    assign tick       = w_tick;
    assign div_out    = w_run && cnt_q[active_sel_q];
    assign taps       = w_run ? cnt_q[3:0] : 4'd0;
    assign y          = taps[0] & taps[2];

`ifdef CLKDIV_TICK_CNT_EN
    logic [7:0] tick_count_q, tick_count_d;
    logic       w_cnt_clear;

    // Cleared when leaving to IDLE or when a held ratio takes effect.
    assign w_cnt_clear = (w_run && !en) || (busy && w_tick);

    always_comb begin
        tick_count_d = tick_count_q;
        if (w_cnt_clear) begin
            tick_count_d = 8'd0;
        end else if (w_tick && (tick_count_q != 8'hFF)) begin
            tick_count_d = tick_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_count_q <= 8'd0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_count = tick_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_clk_div_sched
// Description : Directed self-checking bench for clk_div_sched.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cfg_valid;
    logic [2:0] cfg_sel;
    logic       cfg_ready;
    logic [2:0] active_sel;
    logic       busy;
    logic       div_out;
    logic       tick;
    logic [3:0] taps;
    logic       y;
`ifdef CLKDIV_TICK_CNT_EN
    logic [7:0] tick_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_sched #(
        .CNT_W       (8),
        .DEFAULT_SEL (3'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_sel    (cfg_sel),
        .cfg_ready  (cfg_ready),
        .active_sel (active_sel),
        .busy       (busy),
        .div_out    (div_out),
        .tick       (tick),
        .taps       (taps),
        .y          (y)
`ifdef CLKDIV_TICK_CNT_EN
        ,
        .tick_count (tick_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] kk;
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_sel = 3'd0;
        step(); step();
        checks++;
        if ({cfg_ready, busy, div_out, tick, taps, y, active_sel} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {cfg_ready, busy, div_out, tick, taps, y, active_sel}, 12'h800);
        end
        reset = 1'b0; en = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            kk = 4'(k);
            checks++;
            if ({taps, div_out, tick, y} !== {kk, kk[0], kk[0], kk[0] & kk[2]}) begin
                errors++;
                $display("FAIL div2_count k=%0d: got %h expected %h", k,
                         {taps, div_out, tick, y}, {kk, kk[0], kk[0], kk[0] & kk[2]});
            end
            step();
        end
    endtask

    task automatic test_switch();
        en = 1'b0; step();
        cfg_valid = 1'b1; cfg_sel = 3'd3; step();
        checks++;
        if ({active_sel, taps, busy} !== {3'd3, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL idle_cfg: got %h expected %h", {active_sel, taps, busy}, {3'd3, 4'd0, 1'b0});
        end
        cfg_valid = 1'b0; en = 1'b1; step();
        repeat (5) step();
        checks++;
        if ({taps, cfg_ready, tick} !== {4'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sel3_cnt5: got %h expected %h", {taps, cfg_ready, tick}, {4'd5, 1'b1, 1'b0});
        end
        cfg_valid = 1'b1; cfg_sel = 3'd1; step();
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_ready, busy, active_sel, taps} !== {1'b0, 1'b1, 3'd3, 4'd6}) begin
            errors++;
            $display("FAIL pend_enter: got %h expected %h", {cfg_ready, busy, active_sel, taps}, {1'b0, 1'b1, 3'd3, 4'd6});
        end
        repeat (9) step();
        checks++;
        if ({tick, busy, div_out, taps} !== {1'b1, 1'b1, 1'b1, 4'd15}) begin
            errors++;
            $display("FAIL pend_boundary: got %h expected %h", {tick, busy, div_out, taps}, {1'b1, 1'b1, 1'b1, 4'd15});
        end
        step();
        checks++;
        if ({tick, taps, active_sel, busy, cfg_ready} !== {1'b0, 4'd0, 3'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL switch_applied: got %h expected %h", {tick, taps, active_sel, busy, cfg_ready}, {1'b0, 4'd0, 3'd1, 1'b0, 1'b1});
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (tick !== ((k % 4) == 3)) begin
                errors++;
                $display("FAIL div4_tick k=%0d: got %b expected %b", k, tick, ((k % 4) == 3));
            end
        end
    endtask

    task automatic test_tick_request();
        en = 1'b0; step();
        cfg_valid = 1'b1; cfg_sel = 3'd2; step();
        cfg_valid = 1'b0; en = 1'b1; step();
        repeat (7) step();
        checks++;
        if ({tick, taps} !== {1'b1, 4'd7}) begin
            errors++;
            $display("FAIL sel2_tick_at7: got %h expected %h", {tick, taps}, {1'b1, 4'd7});
        end
        cfg_valid = 1'b1; cfg_sel = 3'd0; step();
        cfg_valid = 1'b0;
        checks++;
        if ({active_sel, taps, busy, tick} !== {3'd2, 4'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL not_applied_at_tick: got %h expected %h", {active_sel, taps, busy, tick}, {3'd2, 4'd8, 1'b1, 1'b0});
        end
        repeat (7) step();
        checks++;
        if ({tick, active_sel, busy} !== {1'b1, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL next_tick_at15: got %h expected %h", {tick, active_sel, busy}, {1'b1, 3'd2, 1'b1});
        end
        step();
        checks++;
        if ({active_sel, taps, busy} !== {3'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL applied_after15: got %h expected %h", {active_sel, taps, busy}, {3'd0, 4'd0, 1'b0});
        end
    endtask

    task automatic test_en_drop_pend();
        cfg_valid = 1'b1; cfg_sel = 3'd5; step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pend5_busy: got %b expected 1", busy);
        end
        cfg_valid = 1'b0; en = 1'b0; step();
        checks++;
        if ({taps, div_out, tick, active_sel, busy, cfg_ready} !== {4'd0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL en_drop_pend: got %h expected %h", {taps, div_out, tick, active_sel, busy, cfg_ready},
                     {4'd0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1});
        end
        repeat (3) step();
        checks++;
        if ({taps, tick, div_out} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", {taps, tick, div_out}, 6'd0);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; step();
        step(); step();
        cfg_valid = 1'b1; cfg_sel = 3'd2; step();
        cfg_valid = 1'b0;
        checks++;
        if ({busy, taps, active_sel} !== {1'b1, 4'd3, 3'd5}) begin
            errors++;
            $display("FAIL pre_reset: got %h expected %h", {busy, taps, active_sel}, {1'b1, 4'd3, 3'd5});
        end
        #2; reset = 1'b1; #1;
        checks++;
        if ({cfg_ready, busy, div_out, tick, taps, y, active_sel} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h",
                     {cfg_ready, busy, div_out, tick, taps, y, active_sel}, 12'h800);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({taps, tick} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL resume_cnt0: got %h expected %h", {taps, tick}, 5'd0);
        end
        step();
        checks++;
        if ({taps, div_out, tick} !== {4'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL resume_cnt1: got %h expected %h", {taps, div_out, tick}, {4'd1, 1'b1, 1'b1});
        end
    endtask

    task automatic test_same_sel();
        cfg_valid = 1'b1; cfg_sel = 3'd0; step();
        cfg_valid = 1'b0;
        checks++;
        if ({busy, taps} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL same_sel_pend: got %h expected %h", {busy, taps}, {1'b1, 4'd2});
        end
        step();
        checks++;
        if ({tick, taps} !== {1'b1, 4'd3}) begin
            errors++;
            $display("FAIL same_sel_tick: got %h expected %h", {tick, taps}, {1'b1, 4'd3});
        end
        step();
        checks++;
        if ({taps, busy, active_sel} !== {4'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL same_sel_restart: got %h expected %h", {taps, busy, active_sel}, 8'd0);
        end
    endtask

    task automatic test_en_cfg_simul();
        step();
        en = 1'b0; cfg_valid = 1'b1; cfg_sel = 3'd6; step();
        cfg_valid = 1'b0;
        checks++;
        if ({taps, active_sel, busy, cfg_ready, div_out} !== {4'd0, 3'd6, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL en_cfg_simul: got %h expected %h", {taps, active_sel, busy, cfg_ready, div_out},
                     {4'd0, 3'd6, 1'b0, 1'b1, 1'b0});
        end
    endtask

`ifdef CLKDIV_TICK_CNT_EN
    task automatic test_tick_count();
        int guard;
        cfg_valid = 1'b1; cfg_sel = 3'd0; step();
        cfg_valid = 1'b0; en = 1'b1; step();
        step(); step();
        checks++;
        if (tick_count !== 8'd1) begin
            errors++;
            $display("FAIL tick_count_first: got %0d expected 1", tick_count);
        end
        repeat (600) step();
        checks++;
        if (tick_count !== 8'd255) begin
            errors++;
            $display("FAIL tick_count_sat: got %0d expected 255", tick_count);
        end
        cfg_valid = 1'b1; cfg_sel = 3'd1; step();
        cfg_valid = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 8) begin
            step();
            guard++;
        end
        checks++;
        if ({busy, active_sel, tick_count} !== {1'b0, 3'd1, 8'd0}) begin
            errors++;
            $display("FAIL tick_count_switch_clear: got %h expected %h", {busy, active_sel, tick_count}, {1'b0, 3'd1, 8'd0});
        end
        repeat (10) step();
        en = 1'b0; step();
        checks++;
        if (tick_count !== 8'd0) begin
            errors++;
            $display("FAIL tick_count_idle_clear: got %0d expected 0", tick_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_switch();
        test_tick_request();
        test_en_drop_pend();
        test_async_reset();
        test_same_sel();
        test_en_cfg_simul();
`ifdef CLKDIV_TICK_CNT_EN
        test_tick_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Single-clock divided-tick scheduler: one free-running counter produces the divided square wave and a tick strobe at clk / 2^(sel+1).
- Same taps as the clock-divider chain, but as clock-enable-style signals in the `clk` domain; no derived clocks.
- Divide-ratio changes use a valid/ready handshake and are applied only at a period boundary, so the output never glitches.
- Sits between the top-level pin wrapper and any logic that needs slow periodic enables.

Parameters:
- CNT_W, 8, counter width; must be >= 8 so sel 0..7 (ratios 2..256) are legal.
- DEFAULT_SEL, 0, active_sel value after reset (3 bits, 0..7).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; 0 forces IDLE.
- cfg_valid  input  1  new ratio request.
- cfg_sel  input  3  requested ratio exponent; ratio = 2^(cfg_sel+1).
- cfg_ready  output  1  request accepted when cfg_valid & cfg_ready on a rising edge.
- active_sel  output  3  ratio exponent currently in effect.
- busy  output  1  a request is held pending, waiting for a boundary.
- div_out  output  1  divided square wave = cnt[active_sel] while RUN; 0 in IDLE.
- tick  output  1  one-cycle strobe on the last cycle of each divided period.
- taps  output  4  cnt[3:0] while RUN (div2/4/8/16 phases); 0 in IDLE.
- y  output  1  taps[0] & taps[2].

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, cnt=0, active_sel=DEFAULT_SEL, pending flag=0.
  - Outputs: cfg_ready=1, busy=0, div_out=0, tick=0, taps=0, y=0.
- States: IDLE, RUN, PEND.
  - IDLE: cnt held at 0.
    - Accepted cfg sets active_sel on the next edge.
    - en=1 moves to RUN on the next edge; the first increment happens on the following edge.
  - RUN: cnt increments by 1 each cycle and wraps modulo 2^CNT_W.
    - tick = (cnt[active_sel:0] all ones), combinational from registers.
    - Accepted cfg stores cfg_sel in pend_sel and moves to PEND.
  - PEND: counting continues with the old active_sel. cfg_ready=0, busy=1.
    - On the edge where tick=1: active_sel<=pend_sel, cnt<=0, back to RUN.
    - The new ratio's first full period starts at count 0.
- cfg_ready = (state!=PEND). Requests are never dropped or overwritten.
- en deasserted in RUN or PEND: next edge goes to IDLE with cnt<=0. Any pending sel is applied at that edge, busy clears.
- Simultaneous events:
  - cfg accepted in RUN on the same cycle as tick: goes to PEND and is applied at the NEXT tick, not this one.
  - en falling on the same cycle as an accepted cfg: go to IDLE with active_sel<=cfg_sel.
  - cfg_sel equal to active_sel: still handshaken; cnt restarts at 0 on the boundary.
- div_out, taps, and y come only from registered cnt/state: glitch-free, zero extra latency.
- Period: with en held high, tick repeats every 2^(active_sel+1) cycles exactly; div_out has 50% duty.

Optional Feature:
- CLKDIV_TICK_CNT_EN.
- Defined: adds output tick_count (8 bits).
  - Increments on every tick, saturating at 255.
  - Cleared to 0 by reset, on entering IDLE, and on the edge applying a new ratio.
- Undefined: port and logic absent; other behaviour is identical.

Test Plan:
- Reset with DEFAULT_SEL=0, en=1 -> div_out toggles every cycle; tick high on every 2nd cycle; taps count 0,1,2,...; y=1 only when cnt[0]=1 and cnt[2]=1.
- sel=3 running, request sel=1 at cnt=5 -> cfg_ready drops, busy=1; switch on the edge after cnt=15 (tick); then cnt=0, active_sel=1, tick every 4 cycles.
- Request issued on the exact tick cycle (sel=2, cnt=7), new sel=0 -> not applied at cnt=7; applied after the next tick at cnt=15 (8 cycles later).
- en dropped while PEND (pend_sel=5) -> next edge: IDLE, cnt=0, div_out=0, active_sel=5, busy=0, cfg_ready=1.
- Async reset pulsed mid-period between edges -> all outputs at reset values before the next clk edge; counting resumes from 0 after release with en=1.
- With CLKDIV_TICK_CNT_EN, sel=0 for 600 cycles -> tick_count saturates at 255; a ratio switch clears it to 0.
